slave_arbitrate_ctrl_wr_ddr: RTL
================================

SLAVE_ARBITRATE_CTRL_WR_DDR -- requirements
Module: slave_arbitrate_ctrl_wr_ddr

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, DDR word-address width per slave.
REQ-002 SHALL have parameter LEN_W, default 10, burst-length width per slave.
REQ-003 SHALL have port ddr_clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port sys_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port slave_req  in  4  per-slave write-burst request, bit k = slave k.
REQ-006 SHALL have port slave_waddr  in  4*ADDR_W  packed start addresses, slave k at [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port slave_wburst_len  in  4*LEN_W  packed burst lengths in beats, same packing.
REQ-008 SHALL have port arbitrate_valid  out  4  one-hot grant, held for the whole transaction.
REQ-009 SHALL have port ddr_cmd_valid  out  1  write-command valid to DDR controller.
REQ-010 SHALL have port ddr_cmd_ready  in  1  command accept; transfer on valid&ready.
REQ-011 SHALL have port ddr_cmd_addr  out  ADDR_W  latched winner address.
REQ-012 SHALL have port ddr_cmd_len  out  LEN_W  latched winner length.
REQ-013 SHALL have port ddr_wdata_req  in  1  controller pulls one data beat this cycle.
REQ-014 SHALL have port fifo_rd_en  out  4  one-hot read strobe to granted slave FIFO.
REQ-015 SHALL have port grant_id  out  2  index of current/last winner.
REQ-016 SHALL have port arb_busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ARB -> CMD -> DATA -> DONE -> IDLE, one state per cycle minimum.
REQ-018 IDLE SHALL go to ARB when any slave_req bit is high, else stay.
REQ-019 ARB (1 cycle) SHALL select winner, latch grant_id, ddr_cmd_addr, ddr_cmd_len from winner slice, then go to CMD.
REQ-020 arbitrate_valid[grant_id] SHALL be registered high from CMD entry through end of DATA, and low in DONE and IDLE.
REQ-021 CMD SHALL assert ddr_cmd_valid, hold addr/len stable until ddr_cmd_ready, then go to DATA (len>0) or DONE (len==0).
REQ-022 DATA SHALL drive fifo_rd_en[grant_id] = ddr_wdata_req combinationally (zero latency), all other bits 0.
REQ-023 DATA SHALL count accepted beats in an LEN_W-bit counter cleared on ARB; go to DONE on the cycle the count reaches ddr_cmd_len.
REQ-024 ddr_wdata_req outside DATA SHALL be ignored; fifo_rd_en SHALL be 0.
REQ-025 DONE (1 cycle) SHALL update priority pointer and return to IDLE; new requests wait for IDLE.
REQ-026 slave_req changes after ARB SHALL NOT affect the in-flight transaction.
REQ-027 Priority pointer: 2-bit; winner = first requesting slave scanning pointer, pointer+1, ... mod 4.

Reset
REQ-028 sys_rst high SHALL immediately force state IDLE, arbitrate_valid=0, ddr_cmd_valid=0, fifo_rd_en=0, ddr_cmd_addr=0, ddr_cmd_len=0, grant_id=0, arb_busy=0, beat counter=0, pointer=0.
REQ-029 Reset mid-transaction SHALL abandon the burst with no further command or read strobe.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: pointer SHALL become grant_id+1 mod 4 in DONE (round robin).
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: pointer SHALL stay 0 (fixed priority, slave 0 highest).

Verification
REQ-032 Only slave_req[2], addr 0x0A00100, len 256, ready on first CMD cycle, wdata_req every cycle -> grant_id=2, cmd addr 0x0A00100 len 256, exactly 256 fifo_rd_en[2] pulses, arbitrate_valid[2] falls in DONE.
REQ-033 All four requests held, len 4 each, macro defined -> grant order 0,1,2,3,0.
REQ-034 Same stimulus, macro undefined -> slave 0 granted every transaction.
REQ-035 slave_req[1], len 0 -> CMD accepted, DATA skipped, zero fifo_rd_en pulses, back to IDLE 2 cycles after accept.
REQ-036 ddr_cmd_ready low 5 cycles -> ddr_cmd_valid, addr, len stable all 5 cycles; transfer on 6th.
REQ-037 sys_rst asserted after 100 of 256 beats -> all outputs 0 in the same cycle, FSM IDLE, pointer 0.

Source files
------------

// File: rtl/slave_arbitrate_ctrl_wr_ddr.sv
// Four-slave write arbiter in front of a DDR controller command/data port.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; otherwise slave 0 always has highest priority.
module slave_arbitrate_ctrl_wr_ddr #(
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 10
) (
    input  logic                  ddr_clk,
    input  logic                  sys_rst,
    input  logic [3:0]            slave_req,
    input  logic [4*ADDR_W-1:0]   slave_waddr,
    input  logic [4*LEN_W-1:0]    slave_wburst_len,
    output logic [3:0]            arbitrate_valid,
    output logic                  ddr_cmd_valid,
    input  logic                  ddr_cmd_ready,
    output logic [ADDR_W-1:0]     ddr_cmd_addr,
    output logic [LEN_W-1:0]      ddr_cmd_len,
    input  logic                  ddr_wdata_req,
    output logic [3:0]            fifo_rd_en,
    output logic [1:0]            grant_id,
    output logic                  arb_busy
);

    // state | meaning
    // IDLE  | wait for any slave_req
    // ARB   | pick winner, latch its address/length, clear beat counter
    // CMD   | present write command until ddr_cmd_ready
    // DATA  | forward ddr_wdata_req to winner's FIFO until len beats moved
    // DONE  | release grant, advance priority pointer
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARB  = 3'd1;
    localparam logic [2:0] CMD  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [1:0]       rr_ptr;
    logic [LEN_W-1:0] beat_cnt;
    logic [1:0]       win_id;
    logic             win_found;
    logic [1:0]       scan_idx;

    // First requester found scanning upward from the pointer, wrapping mod 4.
    always_comb begin
        win_id    = 2'd0;
        win_found = 1'b0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!win_found && slave_req[scan_idx]) begin
                win_id    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ddr_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= IDLE;
            rr_ptr          <= 2'd0;
            beat_cnt        <= '0;
            grant_id        <= 2'd0;
            ddr_cmd_addr    <= '0;
            ddr_cmd_len     <= '0;
            arbitrate_valid <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|slave_req) state <= ARB;
                end
                ARB: begin
                    beat_cnt <= '0;
                    if (win_found) begin
                        grant_id        <= win_id;
                        ddr_cmd_addr    <= slave_waddr[int'(win_id)*ADDR_W +: ADDR_W];
                        ddr_cmd_len     <= slave_wburst_len[int'(win_id)*LEN_W +: LEN_W];
                        arbitrate_valid <= 4'b0001 << win_id;
                        state           <= CMD;
                    end else begin
                        state <= IDLE;
                    end
                end
                CMD: begin
                    if (ddr_cmd_ready) begin
                        if (ddr_cmd_len == '0) begin
                            arbitrate_valid <= 4'd0;
                            state           <= DONE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ddr_wdata_req) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt + LEN_W'(1) == ddr_cmd_len) begin
                            arbitrate_valid <= 4'd0;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr <= grant_id + 2'd1;
`else
                    rr_ptr <= 2'd0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data strobe is combinational so the FIFO sees the controller's pull in the same cycle.
    assign ddr_cmd_valid = (state == CMD);
    assign arb_busy      = (state != IDLE);
    assign fifo_rd_en    = (state == DATA && ddr_wdata_req) ? (4'b0001 << grant_id) : 4'd0;

endmodule
